load_stall_release: RTL and testbench

- Sequential partner of the combinational hazard-detection unit in the 5-stage, 16-register CPU pipeline.
- The hazard unit raises and holds PC, IF/ID and ID/EX stalls on a load-use hazard. This block supplies the `write_done` that releases those stalls.
- It captures the load's destination register and tracks the load to writeback. Meanwhile it forces NOP bubbles into ID/EX.
- It pulses `write_done` once the matching register write has happened, with a timeout backstop.

---
 rtl/load_stall_release_pkg.sv | 13 +
 rtl/load_stall_release.sv | 106 ++++++++++
 tb/tb_load_stall_release.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/load_stall_release_pkg.sv
// Shared CPU pipeline definitions used by the load-use stall release logic.
package load_stall_release_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsr_state_e;

endpackage

// File: rtl/load_stall_release.sv
// Tracks a stalled load to writeback and releases the hazard unit's stalls
// with a one-cycle write_done pulse; forced release after MAX_WAIT cycles.
module load_stall_release
  import load_stall_release_pkg::*;
#(
  parameter int MIN_STALL = 1,
  parameter int MAX_WAIT  = 7,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req,
  input  logic                  e_isLoad,
  input  logic [REG_ADDR_W-1:0] e_wreg,
  input  logic                  w_regwrite,
  input  logic [REG_ADDR_W-1:0] w_wreg,
  output logic                  write_done,
  output logic                  idex_nop,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] pend_wreg,
  output logic                  timeout_err
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W:0]   CNT_MIN = (CNT_W+1)'(MIN_STALL);

  lsr_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  seen_q, seen_d;
  logic [REG_ADDR_W-1:0] pend_q, pend_d;
  logic                  terr_q, terr_d;
  logic                  match;
  logic                  min_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      pend_q  <= REG_ZERO;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    pend_d  = pend_q;
    terr_d  = terr_q;
    match   = w_regwrite && (w_wreg == pend_q);
    // cnt+1 >= MIN_STALL, widened so MIN_STALL=1 is not a compare against zero
    min_ok  = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= CNT_MIN;
    case (state_q)
      ST_IDLE: begin
        if (stall_req && e_isLoad && (e_wreg != REG_ZERO)) begin
          state_d = ST_WAIT;
          pend_d  = e_wreg;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        seen_d = seen_q | match;
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        // A normal release wins over a simultaneous timeout
        if ((seen_q | match) && min_ok) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_TO) begin
          state_d = ST_DONE;
          terr_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs only: write_done must not depend on inputs combinationally
  always_comb begin
    write_done  = 1'b0;
    idex_nop    = 1'b0;
    busy        = 1'b0;
    pend_wreg   = pend_q;
    timeout_err = terr_q;
    case (state_q)
      ST_WAIT: begin
        busy     = 1'b1;
        idex_nop = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b1;
        write_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_stall_release.sv
// Directed bench for load_stall_release: default instance plus a MIN_STALL=3 instance.
module tb_load_stall_release;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_req, e_isLoad, w_regwrite;
  logic [3:0] e_wreg, w_wreg;

  logic       wd, nop, busy, terr;
  logic [3:0] pend;
  logic       wd3, nop3, busy3, terr3;
  logic [3:0] pend3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_stall_release #(.MIN_STALL(1), .MAX_WAIT(7), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .e_isLoad(e_isLoad),
    .e_wreg(e_wreg), .w_regwrite(w_regwrite), .w_wreg(w_wreg),
    .write_done(wd), .idex_nop(nop), .busy(busy), .pend_wreg(pend),
    .timeout_err(terr)
  );

  load_stall_release #(.MIN_STALL(3), .MAX_WAIT(7), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .e_isLoad(e_isLoad),
    .e_wreg(e_wreg), .w_regwrite(w_regwrite), .w_wreg(w_wreg),
    .write_done(wd3), .idex_nop(nop3), .busy(busy3), .pend_wreg(pend3),
    .timeout_err(terr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b0; e_isLoad = 1'b0; e_wreg = 4'd0;
    w_regwrite = 1'b0; w_wreg = 4'd0;
    tick(); tick();
    chk("rst_wd", {3'b0, wd}, 4'd0);
    chk("rst_nop", {3'b0, nop}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_pend", pend, 4'd0);
    chk("rst_terr", {3'b0, terr}, 4'd0);
    rst = 1'b0;

    // Basic release: capture r5, writeback r5 in cycle 2
    stall_req = 1'b1; e_isLoad = 1'b1; e_wreg = 4'd5;
    tick();                                    // cycle 1
    stall_req = 1'b0; e_isLoad = 1'b0; e_wreg = 4'd0;
    chk("basic_c1_busy", {3'b0, busy}, 4'd1);
    chk("basic_c1_nop", {3'b0, nop}, 4'd1);
    chk("basic_c1_wd", {3'b0, wd}, 4'd0);
    tick();                                    // cycle 2
    chk("basic_c2_nop", {3'b0, nop}, 4'd1);
    chk("basic_c2_wd", {3'b0, wd}, 4'd0);
    w_regwrite = 1'b1; w_wreg = 4'd5;
    tick();                                    // cycle 3
    w_regwrite = 1'b0; w_wreg = 4'd0;
    chk("basic_c3_wd", {3'b0, wd}, 4'd1);
    chk("basic_c3_nop", {3'b0, nop}, 4'd0);
    chk("basic_c3_busy", {3'b0, busy}, 4'd1);
    tick();                                    // cycle 4
    chk("basic_c4_wd", {3'b0, wd}, 4'd0);
    chk("basic_c4_busy", {3'b0, busy}, 4'd0);
    chk("basic_c4_pend", pend, 4'd5);
    chk("basic_c4_terr", {3'b0, terr}, 4'd0);
    tick();

    // Early writeback: matching write in the first WAIT cycle
    stall_req = 1'b1; e_isLoad = 1'b1; e_wreg = 4'd3;
    tick();                                    // cycle 1
    stall_req = 1'b0; e_isLoad = 1'b0; e_wreg = 4'd0;
    w_regwrite = 1'b1; w_wreg = 4'd3;
    chk("early_c1_nop3", {3'b0, nop3}, 4'd1);
    tick();                                    // cycle 2
    w_regwrite = 1'b0; w_wreg = 4'd0;
    chk("early_c2_wd3", {3'b0, wd3}, 4'd0);
    chk("early_c2_wd_min1", {3'b0, wd}, 4'd1);
    tick();                                    // cycle 3
    chk("early_c3_wd3", {3'b0, wd3}, 4'd0);
    chk("early_c3_busy3", {3'b0, busy3}, 4'd1);
    tick();                                    // cycle 4
    chk("early_c4_wd3", {3'b0, wd3}, 4'd1);
    chk("early_c4_terr3", {3'b0, terr3}, 4'd0);
    tick();                                    // cycle 5
    chk("early_c5_wd3", {3'b0, wd3}, 4'd0);
    chk("early_c5_pend3", pend3, 4'd3);

    // Mismatch and timeout: capture r7, WB only writes r6
    stall_req = 1'b1; e_isLoad = 1'b1; e_wreg = 4'd7;
    tick();                                    // cycle 1
    stall_req = 1'b0; e_isLoad = 1'b0; e_wreg = 4'd0;
    w_regwrite = 1'b1; w_wreg = 4'd6;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("to_c%0d_wd", c), {3'b0, wd}, 4'd0);
      chk($sformatf("to_c%0d_nop", c), {3'b0, nop}, 4'd1);
      chk($sformatf("to_c%0d_terr", c), {3'b0, terr}, 4'd0);
      tick();
    end                                        // now cycle 8
    chk("to_c8_wd", {3'b0, wd}, 4'd1);
    chk("to_c8_terr", {3'b0, terr}, 4'd1);
    chk("to_c8_wd3", {3'b0, wd3}, 4'd1);
    w_regwrite = 1'b0; w_wreg = 4'd0;
    tick();                                    // cycle 9
    chk("to_c9_wd", {3'b0, wd}, 4'd0);
    chk("to_c9_terr", {3'b0, terr}, 4'd1);
    chk("to_c9_pend", pend, 4'd7);

    // Filtering: r0 destination, then a non-load
    stall_req = 1'b1; e_isLoad = 1'b1; e_wreg = 4'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("filt_r0_busy", {3'b0, busy}, 4'd0);
      chk("filt_r0_wd", {3'b0, wd}, 4'd0);
    end
    e_isLoad = 1'b0; e_wreg = 4'd4;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("filt_nl_busy", {3'b0, busy}, 4'd0);
      chk("filt_nl_wd", {3'b0, wd}, 4'd0);
    end
    chk("filt_pend", pend, 4'd7);
    chk("filt_terr_sticky", {3'b0, terr}, 4'd1);

    // Back-to-back: stall held through DONE, new e_wreg=9 waiting
    stall_req = 1'b1; e_isLoad = 1'b1; e_wreg = 4'd2;
    tick();                                    // cycle 1: WAIT
    e_wreg = 4'd9;
    w_regwrite = 1'b1; w_wreg = 4'd2;
    chk("b2b_c1_busy", {3'b0, busy}, 4'd1);
    tick();                                    // cycle 2: DONE
    w_regwrite = 1'b0; w_wreg = 4'd0;
    chk("b2b_c2_wd", {3'b0, wd}, 4'd1);
    chk("b2b_c2_pend", pend, 4'd2);
    tick();                                    // cycle 3: IDLE, request seen
    chk("b2b_c3_busy", {3'b0, busy}, 4'd0);
    chk("b2b_c3_pend", pend, 4'd2);
    tick();                                    // cycle 4: WAIT on r9
    stall_req = 1'b0; e_isLoad = 1'b0; e_wreg = 4'd0;
    chk("b2b_c4_nop", {3'b0, nop}, 4'd1);
    chk("b2b_c4_pend", pend, 4'd9);
    tick();                                    // cycle 5: 2nd WAIT cycle

    // Reset mid-WAIT with a tempting matching write
    chk("rmid_busy_pre", {3'b0, busy}, 4'd1);
    rst = 1'b1; w_regwrite = 1'b1; w_wreg = 4'd9;
    tick();
    chk("rmid_wd", {3'b0, wd}, 4'd0);
    chk("rmid_busy", {3'b0, busy}, 4'd0);
    chk("rmid_nop", {3'b0, nop}, 4'd0);
    chk("rmid_pend", pend, 4'd0);
    chk("rmid_terr", {3'b0, terr}, 4'd0);
    rst = 1'b0; w_regwrite = 1'b0; w_wreg = 4'd0;
    tick();
    chk("rmid_post_wd", {3'b0, wd}, 4'd0);
    chk("rmid_post_busy", {3'b0, busy}, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
